// File: rtl/sti_share_encoder.sv
// Splits each unshared S-box input byte into two Boolean shares using a 16-bit LFSR mask.
// After a set number of sharings the block stops taking input until it is given a new seed.
//
// state     | meaning
// UNSEEDED  | no seed loaded since reset; input is refused
// RUN       | seeded; input is accepted subject to output backpressure
// EXHAUSTED | sharing budget used up; a pending output can still drain, but input is refused
module sti_share_encoder #(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
  parameter logic [15:0] RESEED_LIMIT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_valid,
  input  logic [15:0] seed,
  input  logic        in_valid,
  input  logic [7:0]  in,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out,
  input  logic        out_ready,
  output logic        reseed_req
);

  typedef enum logic [1:0] {UNSEEDED, RUN, EXHAUSTED} state_t;

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [15:0] lfsr_step;
  logic [15:0] cnt;
  logic        hs;
  logic        limit_hit;

  assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // A seed load takes the cycle, so it blocks the handshake.
  assign in_ready   = (state == RUN) & ~seed_valid & (~out_valid | out_ready);
  assign hs         = in_valid & in_ready;
  assign limit_hit  = ({1'b0, cnt} + 17'd1) == {1'b0, RESEED_LIMIT};
  assign reseed_req = (state == EXHAUSTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= UNSEEDED;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (seed_valid)
      state_nxt = RUN;
    else if (hs && limit_hit)
      state_nxt = EXHAUSTED;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr      <= SEED_DEFAULT;
      cnt       <= 16'd0;
      out       <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      // An all-zero seed would lock the LFSR, so swap in the default.
      if (seed_valid) begin
        lfsr <= (seed == 16'h0000) ? SEED_DEFAULT : seed;
        cnt  <= 16'd0;
      end else if (hs) begin
        lfsr <= lfsr_step;
        cnt  <= cnt + 16'd1;
      end

      if (hs) begin
        out       <= {in ^ lfsr[7:0], lfsr[7:0]};
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
